// File: rtl/aes_pkg.sv
// Shared AES helpers: block-size legality, ShiftRows row offsets and the column-major byte index.
// Used by the shift-rows, mix-columns and add-round-key stages.
package aes_pkg;

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  // Rijndael uses offsets 0,1,2,3 for NB=4/6 but 0,1,3,4 for NB=8
  function automatic int shift_of(input int nb, input int r);
    if ((nb == 8) && (r >= 2)) return r + 1;
    return r;
  endfunction

  function automatic int byte_idx(input int r, input int c);
    return 4 * c + r;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation; all source indices are fixed at elaboration.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter  int NB = 4,
  localparam int W  = 32 * NB
) (
  input  logic [W-1:0] data,
  input  logic         inv,
  output logic [W-1:0] perm_data
);

  genvar r, c;
  generate
    for (r = 0; r < 4; r++) begin : g_row
      for (c = 0; c < NB; c++) begin : g_col
        localparam int S       = shift_of(NB, r);
        localparam int FWD_SRC = (c + S) % NB;
        localparam int INV_SRC = (c - S + NB) % NB;
        localparam int DST_BIT = W - 1 - 8 * byte_idx(r, c);
        localparam int FWD_BIT = W - 1 - 8 * byte_idx(r, FWD_SRC);
        localparam int INV_BIT = W - 1 - 8 * byte_idx(r, INV_SRC);

        assign perm_data[DST_BIT -: 8] = inv ? data[INV_BIT -: 8] : data[FWD_BIT -: 8];
      end
    end
  endgenerate

endmodule

// File: rtl/shift_rows_pipe.sv
// Registered ShiftRows / InvShiftRows stage: permutation in front of a 2-entry elastic buffer
// with valid/ready handshaking on both sides.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter  int NB = 4,
  localparam int W  = 32 * NB
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  if (!nb_legal(NB)) begin : g_nb_check
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  logic [W-1:0] perm_data;
  logic [W-1:0] entry [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         push;
  logic         pop;

  shift_rows_perm #(.NB(NB)) u_perm (
    .data      (in_data),
    .inv       (in_inv),
    .perm_data (perm_data)
  );

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign out_data  = entry[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Entries are cleared on reset so out_data never carries X or stale beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      entry[0] <= '0;
      entry[1] <= '0;
    end else begin
      if (push) begin
        entry[wr_ptr] <= perm_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Scoreboard bench for shift_rows_pipe: NB=4 and NB=8 instances, directed vectors plus a reference permutation.
module tb_shift_rows_pipe;

  logic         clk = 1'b0;
  logic         rst_n;

  logic         in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [127:0] in_data, out_data;

  logic         in_valid8, in_ready8, in_inv8, out_valid8, out_ready8;
  logic [255:0] in_data8, out_data8;

  int errors = 0;
  int checks = 0;

  logic [255:0] q4 [$];
  logic [255:0] q8 [$];

  localparam logic [127:0] VEC_A = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] VEC_B = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  always #5 clk = ~clk;

  shift_rows_pipe #(.NB(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  shift_rows_pipe #(.NB(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_data   (in_data8),
    .in_inv    (in_inv8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_data  (out_data8)
  );

  // Reference ShiftRows written directly from the Rijndael row-offset table
  function automatic logic [255:0] model(input logic [255:0] d, input int nb, input bit inv);
    int sh [4];
    int w;
    int src;
    logic [255:0] o;
    o = '0;
    w = 32 * nb;
    if (nb == 8) sh = '{0, 1, 3, 4};
    else         sh = '{0, 1, 2, 3};
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - sh[r] + nb) % nb : (c + sh[r]) % nb;
        o[w-1-8*(4*c+r) -: 8] = d[w-1-8*(4*src+r) -: 8];
      end
    end
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one NB=4 beat and holds it until accepted; returns on the negedge after acceptance
  task automatic applyStimulus(input logic [127:0] d, input bit inv, input logic [127:0] exp);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1");
      return;
    end
    q4.push_back({128'b0, exp});
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q4.size() == 0) checkOutput("unexpected_out4", {128'b0, out_data}, '0);
      else checkOutput("out4", {128'b0, out_data}, q4.pop_front());
    end
    if (rst_n && out_valid8 && out_ready8) begin
      if (q8.size() == 0) checkOutput("unexpected_out8", out_data8, '0);
      else checkOutput("out8", out_data8, q8.pop_front());
    end
  end

  initial begin
    logic [127:0] x, y, held;
    logic [255:0] seq8;
    int n;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_data8 = '0; in_inv8 = 1'b0; out_ready8 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset checks");
    checkOutput("rst_out_valid", {255'b0, out_valid}, 256'd0);
    checkOutput("rst_in_ready", {255'b0, in_ready}, 256'd1);
    checkOutput("rst_out_data", {128'b0, out_data}, 256'd0);
    checkOutput("rst_out_valid8", {255'b0, out_valid8}, 256'd0);

    $display("[TB] AES forward vector, single beat");
    applyStimulus(VEC_A, 1'b0, VEC_B);
    in_valid = 1'b0;
    checkOutput("lat1_valid", {255'b0, out_valid}, 256'd1);
    @(negedge clk);
    checkOutput("single_valid_drop", {255'b0, out_valid}, 256'd0);

    $display("[TB] AES inverse vector");
    applyStimulus(VEC_B, 1'b1, VEC_A);
    in_valid = 1'b0;
    @(negedge clk);

    $display("[TB] alternating inverse flag at full rate");
    applyStimulus(VEC_A, 1'b0, VEC_B);
    applyStimulus(VEC_B, 1'b1, VEC_A);
    applyStimulus(VEC_A, 1'b0, VEC_B);
    applyStimulus(VEC_B, 1'b1, VEC_A);
    in_valid = 1'b0;
    @(negedge clk);

    $display("[TB] round trip on random states");
    for (int i = 0; i < 16; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      y = model({128'b0, x}, 4, 1'b0);
      applyStimulus(x, 1'b0, y);
      applyStimulus(y, 1'b1, x);
    end
    in_valid = 1'b0;
    @(negedge clk);

    $display("[TB] backpressure with five back-to-back beats");
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          x = {$urandom, $urandom, $urandom, $urandom};
          applyStimulus(x, i[0], model({128'b0, x}, 4, i[0]));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(negedge clk);
        checkOutput("bp_in_ready_low", {255'b0, in_ready}, 256'd0);
        checkOutput("bp_out_valid", {255'b0, out_valid}, 256'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
          checkOutput("bp_full_rate", {255'b0, out_valid}, 256'd1);
          @(negedge clk);
        end
      end
    join
    @(negedge clk);

    $display("[TB] NB=8 forward and inverse");
    for (int k = 0; k < 32; k++) seq8[255-8*k -: 8] = k[7:0];
    in_valid8 = 1'b1; in_data8 = seq8; in_inv8 = 1'b0;
    checkOutput("nb8_in_ready", {255'b0, in_ready8}, 256'd1);
    q8.push_back(model(seq8, 8, 1'b0));
    @(negedge clk);
    checkOutput("nb8_col0", {224'b0, out_data8[255:224]}, {224'b0, 32'h00050e13});
    in_data8 = seq8; in_inv8 = 1'b1;
    q8.push_back(model(seq8, 8, 1'b1));
    @(negedge clk);
    in_valid8 = 1'b0;
    @(negedge clk);

    $display("[TB] reset during a full stall");
    out_ready = 1'b0;
    applyStimulus(VEC_A, 1'b0, VEC_B);
    applyStimulus(VEC_B, 1'b1, VEC_A);
    in_valid = 1'b0;
    checkOutput("stall_in_ready", {255'b0, in_ready}, 256'd0);
    held = out_data;
    @(negedge clk);
    checkOutput("stall_hold_data", {128'b0, out_data}, {128'b0, held});
    checkOutput("stall_hold_valid", {255'b0, out_valid}, 256'd1);
    rst_n = 1'b0;
    q4.delete();
    #1;
    checkOutput("async_rst_valid", {255'b0, out_valid}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_valid", {255'b0, out_valid}, 256'd0);
    checkOutput("post_rst_in_ready", {255'b0, in_ready}, 256'd1);
    checkOutput("post_rst_data", {128'b0, out_data}, 256'd0);
    out_ready = 1'b1;
    x = 128'h00112233445566778899aabbccddeeff;
    applyStimulus(x, 1'b0, 128'h0055aaff4499ee3388dd2277cc1166bb);
    in_valid = 1'b0;

    n = 0;
    while ((q4.size() != 0 || q8.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q4.size() != 0 || q8.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", q4.size() + q8.size());
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
